// File: rtl/fft_rad2_iter_pkg.sv
// -----------------------------------------------------------------------------
// fft_rad2_iter_pkg
// Shared definitions for the iterative radix-2 FFT engine:
//   state_t : FSM states (LOAD -> CALC -> UNLOAD -> LOAD)
//   bitrev  : reverse the low nbits bits of an index (input reordering for DIT)
//   sat     : clamp a wide signed value to a signed range of 'width' bits
// No ports (package).
// -----------------------------------------------------------------------------
package fft_rad2_iter_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_CALC   = 2'd1,
        S_UNLOAD = 2'd2
    } state_t;

    // Working width of the generic saturation helper.
    localparam int SAT_W = 64;

    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < nbits; i++) begin
            r = (r << 1) | ((idx >> i) & 32'd1);
        end
        return r;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                    input int unsigned            width);
        logic signed [SAT_W-1:0] vmax;
        logic signed [SAT_W-1:0] vmin;
        vmax = (64'sd1 <<< (width - 1)) - 64'sd1;
        vmin = -vmax - 64'sd1;
        if (v > vmax) return vmax;
        if (v < vmin) return vmin;
        return v;
    endfunction

endpackage

// File: rtl/fft_rad2_iter_bfly.sv
// -----------------------------------------------------------------------------
// fft_rad2_bfly
// Combinational radix-2 DIT butterfly:
//   P = (B * W) >>> TW_FRAC   (full-precision complex product, truncated)
//   X = A + P,  Y = A - P     (optionally >>>1 when SCALE, then saturated)
// Ports:
//   i_a_r/i_a_i, i_b_r/i_b_i : complex inputs A and B (DATA_W signed)
//   i_w_r/i_w_i              : twiddle W (TW_W signed, TW_FRAC fraction bits)
//   i_conj                   : use conj(W) (inverse transform)
//   o_x_r/o_x_i, o_y_r/o_y_i : complex outputs X and Y (DATA_W signed)
// -----------------------------------------------------------------------------
module fft_rad2_bfly
    import fft_rad2_iter_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TW_W    = 16,
    parameter int TW_FRAC = 8,
    parameter int SCALE   = 0
) (
    input  logic signed [DATA_W-1:0] i_a_r,
    input  logic signed [DATA_W-1:0] i_a_i,
    input  logic signed [DATA_W-1:0] i_b_r,
    input  logic signed [DATA_W-1:0] i_b_i,
    input  logic signed [TW_W-1:0]   i_w_r,
    input  logic signed [TW_W-1:0]   i_w_i,
    input  logic                     i_conj,
    output logic signed [DATA_W-1:0] o_x_r,
    output logic signed [DATA_W-1:0] o_x_i,
    output logic signed [DATA_W-1:0] o_y_r,
    output logic signed [DATA_W-1:0] o_y_i
);

    // One extra twiddle bit so that negating the most negative value is exact.
    localparam int WE_W = TW_W + 1;
    // Product plus one bit for the two-term complex sum.
    localparam int PW   = DATA_W + WE_W + 1;
    // Headroom for A +/- P before scaling and saturation.
    localparam int SW   = PW + 1;

    function automatic logic signed [SW-1:0] scale_fn(input logic signed [SW-1:0] v);
        return (SCALE != 0) ? (v >>> 1) : v;
    endfunction

    function automatic logic signed [DATA_W-1:0] clip(input logic signed [SW-1:0] v);
        logic signed [SAT_W-1:0] t;
        t = sat(SAT_W'(v), DATA_W);
        return t[DATA_W-1:0];
    endfunction

    logic signed [WE_W-1:0] w_wr;
    logic signed [WE_W-1:0] w_wi;
    logic signed [PW-1:0]   w_br;
    logic signed [PW-1:0]   w_bi;
    logic signed [PW-1:0]   w_pr;
    logic signed [PW-1:0]   w_pi;
    logic signed [SW-1:0]   w_xr;
    logic signed [SW-1:0]   w_xi;
    logic signed [SW-1:0]   w_yr;
    logic signed [SW-1:0]   w_yi;

    always_comb begin
        w_wr = WE_W'(i_w_r);
        w_wi = i_conj ? -WE_W'(i_w_i) : WE_W'(i_w_i);
    end

    assign w_br = PW'(i_b_r);
    assign w_bi = PW'(i_b_i);

    // Truncating arithmetic shift drops the twiddle fraction.
    assign w_pr = (w_br * PW'(w_wr) - w_bi * PW'(w_wi)) >>> TW_FRAC;
    assign w_pi = (w_br * PW'(w_wi) + w_bi * PW'(w_wr)) >>> TW_FRAC;

    assign w_xr = SW'(i_a_r) + SW'(w_pr);
    assign w_xi = SW'(i_a_i) + SW'(w_pi);
    assign w_yr = SW'(i_a_r) - SW'(w_pr);
    assign w_yi = SW'(i_a_i) - SW'(w_pi);

    assign o_x_r = clip(scale_fn(w_xr));
    assign o_x_i = clip(scale_fn(w_xi));
    assign o_y_r = clip(scale_fn(w_yr));
    assign o_y_i = clip(scale_fn(w_yi));

endmodule

// File: rtl/fft_rad2_iter.sv
// -----------------------------------------------------------------------------
// fft_rad2_iter
// Frame-based in-place radix-2 DIT FFT/IFFT with one time-shared butterfly.
// LOAD accepts N samples two per beat into bit-reversed slots, CALC runs
// (N/2)*log2(N) butterflies (one per cycle), UNLOAD returns bins in natural
// order two per beat under valid/ready.
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_in_valid / o_in_ready : input pair handshake (ready only in LOAD)
//   i_inverse               : 0 = FFT, 1 = IFFT, captured on a frame's first beat
//   i_data_{0,1}_{r,i}      : samples 2k, 2k+1
//   i_tw_r, i_tw_i          : static twiddles W_N^k, k = 0..N/2-1
//   o_out_valid / i_out_ready, o_out_last : output pair handshake, last pair flag
//   o_out_{0,1}_{r,i}       : bins 2k, 2k+1 (registered)
// -----------------------------------------------------------------------------
module fft_rad2_iter
    import fft_rad2_iter_pkg::*;
#(
    parameter int N       = 8,
    parameter int DATA_W  = 16,
    parameter int TW_W    = 16,
    parameter int TW_FRAC = 8,
    parameter int SCALE   = 0
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic                        i_inverse,
    input  logic signed [DATA_W-1:0]    i_data_0_r,
    input  logic signed [DATA_W-1:0]    i_data_0_i,
    input  logic signed [DATA_W-1:0]    i_data_1_r,
    input  logic signed [DATA_W-1:0]    i_data_1_i,
    input  logic [N/2-1:0][TW_W-1:0]    i_tw_r,
    input  logic [N/2-1:0][TW_W-1:0]    i_tw_i,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic                        o_out_last,
    output logic signed [DATA_W-1:0]    o_out_0_r,
    output logic signed [DATA_W-1:0]    o_out_0_i,
    output logic signed [DATA_W-1:0]    o_out_1_r,
    output logic signed [DATA_W-1:0]    o_out_1_i
);

    localparam int LOG2N = $clog2(N);
    localparam int HALF  = N / 2;
    localparam int AW    = LOG2N;          // array address width
    localparam int KW    = LOG2N - 1;      // beat / butterfly / pair index width
    localparam int STW   = $clog2(LOG2N);  // stage counter width

    // Register array (no reset: contents are don't-care until loaded).
    logic signed [DATA_W-1:0] r_mem_r [N];
    logic signed [DATA_W-1:0] r_mem_i [N];

    state_t                   r_state;
    // Shared index: input beat in LOAD, butterfly in CALC, output pair in UNLOAD.
    logic [KW-1:0]            r_idx;
    logic [STW-1:0]           r_stage;
    logic                     r_inv;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic signed [DATA_W-1:0] r_out_0_r;
    logic signed [DATA_W-1:0] r_out_0_i;
    logic signed [DATA_W-1:0] r_out_1_r;
    logic signed [DATA_W-1:0] r_out_1_i;

    logic [AW-1:0]            w_addr_a;
    logic [AW-1:0]            w_addr_b;
    logic [KW-1:0]            w_tw_idx;
    logic [AW-1:0]            w_ld0;
    logic [AW-1:0]            w_ld1;
    logic [KW-1:0]            w_nxt_idx;
    logic [AW-1:0]            w_nxt0;
    logic [AW-1:0]            w_nxt1;
    logic signed [DATA_W-1:0] w_x_r;
    logic signed [DATA_W-1:0] w_x_i;
    logic signed [DATA_W-1:0] w_y_r;
    logic signed [DATA_W-1:0] w_y_i;

    // Butterfly k of stage s (span h = 2^s): group g = k >> s, position j = k mod h.
    // Pair is (g*2h + j, g*2h + j + h); twiddle index j * N/(2h) = j << (log2N-1-s).
    always_comb begin
        int s;
        int idx;
        int j;
        int base;
        s        = int'(r_stage);
        idx      = int'(r_idx);
        j        = idx & ((1 << s) - 1);
        base     = ((idx >> s) << (s + 1)) | j;
        w_addr_a = AW'(base);
        w_addr_b = AW'(base + (1 << s));
        w_tw_idx = KW'(j << (KW - s));
    end

    // Samples 2k and 2k+1 land at their bit-reversed slots.
    assign w_ld0 = AW'(bitrev(32'({r_idx, 1'b0}), LOG2N));
    assign w_ld1 = AW'(bitrev(32'({r_idx, 1'b1}), LOG2N));

    assign w_nxt_idx = r_idx + 1'b1;
    assign w_nxt0    = {w_nxt_idx, 1'b0};
    assign w_nxt1    = {w_nxt_idx, 1'b1};

    fft_rad2_bfly #(
        .DATA_W  (DATA_W),
        .TW_W    (TW_W),
        .TW_FRAC (TW_FRAC),
        .SCALE   (SCALE)
    ) u_bfly (
        .i_a_r  (r_mem_r[w_addr_a]),
        .i_a_i  (r_mem_i[w_addr_a]),
        .i_b_r  (r_mem_r[w_addr_b]),
        .i_b_i  (r_mem_i[w_addr_b]),
        .i_w_r  ($signed(i_tw_r[w_tw_idx])),
        .i_w_i  ($signed(i_tw_i[w_tw_idx])),
        .i_conj (r_inv),
        .o_x_r  (w_x_r),
        .o_x_i  (w_x_i),
        .o_y_r  (w_y_r),
        .o_y_i  (w_y_i)
    );

    // Array write port: input beats in LOAD, in-place butterfly results in CALC.
    always_ff @(posedge i_clk) begin
        if (r_state == S_LOAD && i_in_valid) begin
            r_mem_r[w_ld0] <= i_data_0_r;
            r_mem_i[w_ld0] <= i_data_0_i;
            r_mem_r[w_ld1] <= i_data_1_r;
            r_mem_i[w_ld1] <= i_data_1_i;
        end else if (r_state == S_CALC) begin
            r_mem_r[w_addr_a] <= w_x_r;
            r_mem_i[w_addr_a] <= w_x_i;
            r_mem_r[w_addr_b] <= w_y_r;
            r_mem_i[w_addr_b] <= w_y_i;
        end
    end

    // Control FSM with registered handshake flags and output pair.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_LOAD;
            r_idx       <= '0;
            r_stage     <= '0;
            r_inv       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_0_r   <= '0;
            r_out_0_i   <= '0;
            r_out_1_r   <= '0;
            r_out_1_i   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (i_in_valid) begin
                        if (r_idx == '0) begin
                            r_inv <= i_inverse;
                        end
                        if (r_idx == KW'(HALF - 1)) begin
                            r_idx      <= '0;
                            r_stage    <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_CALC;
                        end else begin
                            r_idx <= w_nxt_idx;
                        end
                    end
                end
                S_CALC: begin
                    if (r_idx == KW'(HALF - 1)) begin
                        r_idx <= '0;
                        if (r_stage == STW'(LOG2N - 1)) begin
                            // The final butterfly writes slots N/2-1 and N-1, so
                            // slots 0 and 1 are already final here (N >= 8).
                            r_state     <= S_UNLOAD;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            r_out_0_r   <= r_mem_r[0];
                            r_out_0_i   <= r_mem_i[0];
                            r_out_1_r   <= r_mem_r[1];
                            r_out_1_i   <= r_mem_i[1];
                        end else begin
                            r_stage <= r_stage + 1'b1;
                        end
                    end else begin
                        r_idx <= w_nxt_idx;
                    end
                end
                S_UNLOAD: begin
                    if (i_out_ready) begin
                        if (r_idx == KW'(HALF - 1)) begin
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_LOAD;
                        end else begin
                            r_idx      <= w_nxt_idx;
                            r_out_last <= (w_nxt_idx == KW'(HALF - 1));
                            r_out_0_r  <= r_mem_r[w_nxt0];
                            r_out_0_i  <= r_mem_i[w_nxt0];
                            r_out_1_r  <= r_mem_r[w_nxt1];
                            r_out_1_i  <= r_mem_i[w_nxt1];
                        end
                    end
                end
                default: begin
                    r_state     <= S_LOAD;
                    r_idx       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_out_0_r   = r_out_0_r;
    assign o_out_0_i   = r_out_0_i;
    assign o_out_1_r   = r_out_1_r;
    assign o_out_1_i   = r_out_1_i;

endmodule

// File: tb/tb_fft_rad2_iter.sv
// -----------------------------------------------------------------------------
// tb_fft_rad2_iter
// Directed bench for fft_rad2_iter at N=8 with Q8 twiddles. Two instances run
// in lockstep on the same stimulus: u_dut0 with SCALE=0, u_dut1 with SCALE=1.
// -----------------------------------------------------------------------------
module tb_fft_rad2_iter;

    localparam int N    = 8;
    localparam int DW   = 16;
    localparam int TWW  = 16;
    localparam int HALF = N / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 in_valid;
    logic                 inverse;
    logic                 out_ready;
    logic signed [DW-1:0] d0r, d0i, d1r, d1i;
    logic [HALF-1:0][TWW-1:0] twr, twi;

    logic                 in_ready0, out_valid0, out_last0;
    logic                 in_ready1, out_valid1, out_last1;
    logic signed [DW-1:0] a0r, a0i, a1r, a1i;
    logic signed [DW-1:0] b0r, b0i, b1r, b1i;

    int total = 0;
    int bad   = 0;
    int xr  [N];
    int xi  [N];
    int e0r [N];
    int e0i [N];
    int e1r [N];
    int e1i [N];
    int g0r [N];
    int g0i [N];
    int g1r [N];
    int g1i [N];
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    fft_rad2_iter #(.N(N), .DATA_W(DW), .TW_W(TWW), .TW_FRAC(8), .SCALE(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready0),
        .i_inverse(inverse),
        .i_data_0_r(d0r), .i_data_0_i(d0i), .i_data_1_r(d1r), .i_data_1_i(d1i),
        .i_tw_r(twr), .i_tw_i(twi),
        .o_out_valid(out_valid0), .i_out_ready(out_ready), .o_out_last(out_last0),
        .o_out_0_r(a0r), .o_out_0_i(a0i), .o_out_1_r(a1r), .o_out_1_i(a1i)
    );

    fft_rad2_iter #(.N(N), .DATA_W(DW), .TW_W(TWW), .TW_FRAC(8), .SCALE(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready1),
        .i_inverse(inverse),
        .i_data_0_r(d0r), .i_data_0_i(d0i), .i_data_1_r(d1r), .i_data_1_i(d1i),
        .i_tw_r(twr), .i_tw_i(twi),
        .o_out_valid(out_valid1), .i_out_ready(out_ready), .o_out_last(out_last1),
        .o_out_0_r(b0r), .o_out_0_i(b0i), .o_out_1_r(b1r), .o_out_1_i(b1i)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            xr[i] = 0;  xi[i] = 0;
            e0r[i] = 0; e0i[i] = 0;
            e1r[i] = 0; e1i[i] = 0;
        end
    endtask

    task automatic send_frame(input bit inv);
        for (int b = 0; b < HALF; b++) begin
            d0r = DW'(xr[2*b]);   d0i = DW'(xi[2*b]);
            d1r = DW'(xr[2*b+1]); d1i = DW'(xi[2*b+1]);
            in_valid = 1'b1;
            // Only the first beat's mode counts; later beats flip it.
            inverse  = (b == 0) ? inv : ~inv;
            @(negedge clk);
            if (b == 0) chk("in_ready_load", int'(in_ready0), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        inverse  = 1'b0;
        d0r = '0; d0i = '0; d1r = '0; d1i = '0;
    endtask

    task automatic wait_latency(input string name);
        int lat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid0 && lat < 100);
        chk($sformatf("%s_latency", name), lat, 12);
    endtask

    task automatic recv_frame(input bit use_pat, input string name);
        int k;
        int cyc;
        bit stall;
        int h0r, h0i, h1r, h1i;
        k = 0; cyc = 0; stall = 1'b0;
        h0r = 0; h0i = 0; h1r = 0; h1i = 0;
        while (k < HALF && cyc < 200) begin
            out_ready = use_pat ? pat[cyc % 7] : 1'b1;
            @(negedge clk);
            chk($sformatf("%s_inrdy_unload", name), int'(in_ready0), 0);
            if (stall) begin
                chk($sformatf("%s_hold_valid", name), int'(out_valid0), 1);
                chk($sformatf("%s_hold_0r", name), int'(a0r), h0r);
                chk($sformatf("%s_hold_0i", name), int'(a0i), h0i);
                chk($sformatf("%s_hold_1r", name), int'(a1r), h1r);
                chk($sformatf("%s_hold_1i", name), int'(a1i), h1i);
            end
            stall = 1'b0;
            if (out_valid0) begin
                if (out_ready) begin
                    g0r[2*k] = int'(a0r); g0i[2*k] = int'(a0i);
                    g0r[2*k+1] = int'(a1r); g0i[2*k+1] = int'(a1i);
                    g1r[2*k] = int'(b0r); g1i[2*k] = int'(b0i);
                    g1r[2*k+1] = int'(b1r); g1i[2*k+1] = int'(b1i);
                    chk($sformatf("%s_last_k%0d", name, k), int'(out_last0), (k == HALF-1) ? 1 : 0);
                    k++;
                end else begin
                    stall = 1'b1;
                    h0r = int'(a0r); h0i = int'(a0i); h1r = int'(a1r); h1i = int'(a1i);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        if (k < HALF) chk($sformatf("%s_unload_timeout", name), k, HALF);
        chk($sformatf("%s_inrdy_after", name), int'(in_ready0), 1);
        chk($sformatf("%s_ovld_after", name), int'(out_valid0), 0);
    endtask

    task automatic check_bins(input string name, input bit with1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_s0_b%0d_r", name, i), g0r[i], e0r[i]);
            chk($sformatf("%s_s0_b%0d_i", name, i), g0i[i], e0i[i]);
            if (with1) begin
                chk($sformatf("%s_s1_b%0d_r", name, i), g1r[i], e1r[i]);
                chk($sformatf("%s_s1_b%0d_i", name, i), g1i[i], e1i[i]);
            end
        end
    endtask

    task automatic run_frame(input bit inv, input bit use_pat, input string name, input bit with1);
        send_frame(inv);
        wait_latency(name);
        recv_frame(use_pat, name);
        check_bins(name, with1);
    endtask

    // Expected bins for a unit impulse at x1 (forward): W8^k in Q8.
    task automatic exp_x1_fwd();
        clear_all();
        xr[1] = 256;
        e0r = '{256, 181, 0, -181, -256, -181, 0, 181};
        e0i = '{0, -181, -256, -181, 0, 181, 256, 181};
    endtask

    initial begin
        int seen;
        twr[0] = TWW'(256);  twi[0] = TWW'(0);
        twr[1] = TWW'(181);  twi[1] = TWW'(-181);
        twr[2] = TWW'(0);    twi[2] = TWW'(-256);
        twr[3] = TWW'(-181); twi[3] = TWW'(-181);
        rst = 1'b1; in_valid = 1'b0; inverse = 1'b0; out_ready = 1'b1;
        d0r = '0; d0i = '0; d1r = '0; d1i = '0;
        for (int i = 0; i < N; i++) begin
            g0r[i] = 0; g0i[i] = 0; g1r[i] = 0; g1i[i] = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready0), 1);
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_out_last", int'(out_last0), 0);
        chk("rst_out_0r", int'(a0r), 0);
        chk("rst_out_1i", int'(a1i), 0);
        @(posedge clk); #1;

        // Impulse at x0: flat spectrum; SCALE=1 divides by 8.
        clear_all();
        xr[0] = 256;
        for (int i = 0; i < N; i++) begin e0r[i] = 256; e1r[i] = 32; end
        run_frame(1'b0, 1'b0, "imp0", 1'b1);

        // Impulse at x1, forward.
        exp_x1_fwd();
        run_frame(1'b0, 1'b0, "imp1", 1'b0);

        // Impulse at x1, inverse: conjugate twiddles.
        clear_all();
        xr[1] = 256;
        e0r = '{256, 181, 0, -181, -256, -181, 0, 181};
        e0i = '{0, 181, 256, 181, 0, -181, -256, -181};
        run_frame(1'b1, 1'b0, "ifft1", 1'b0);

        // DC
        clear_all();
        for (int i = 0; i < N; i++) xr[i] = 256;
        e0r[0] = 2048; e1r[0] = 256;
        run_frame(1'b0, 1'b0, "dc", 1'b1);

        // IFFT of bin0 = 2048.
        clear_all();
        xr[0] = 2048;
        for (int i = 0; i < N; i++) begin e0r[i] = 2048; e1r[i] = 256; end
        run_frame(1'b1, 1'b0, "idc", 1'b1);

        // Saturation
        clear_all();
        for (int i = 0; i < N; i++) xr[i] = 32767;
        e0r[0] = 32767; e1r[0] = 32767;
        run_frame(1'b0, 1'b0, "sat", 1'b1);

        // Backpressure, then a back-to-back frame.
        exp_x1_fwd();
        run_frame(1'b0, 1'b1, "bp", 1'b0);
        clear_all();
        for (int i = 0; i < N; i++) xr[i] = 256;
        e0r[0] = 2048; e1r[0] = 256;
        run_frame(1'b0, 1'b0, "b2b", 1'b1);

        // Reset mid-CALC aborts the frame.
        exp_x1_fwd();
        send_frame(1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready0), 1);
        chk("midrst_out_valid", int'(out_valid0), 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid0) seen++;
        end
        chk("midrst_no_partial", seen, 0);
        @(posedge clk); #1;
        clear_all();
        xr[0] = 256;
        for (int i = 0; i < N; i++) begin e0r[i] = 256; e1r[i] = 32; end
        run_frame(1'b0, 1'b0, "post_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
